gbt_rx_pattern_checker: RTL and testbench

Receive-side consumer of the GBT link's received data field, in the 40 MHz frame-clock domain.
- Verifies that the far end transmits a free-running incrementing counter.
- Uses a lock/unlock state machine with a flywheel expected-value generator.
- Maintains saturating error, frame and loss-of-lock counters for diagnostics and LED/status reporting.
- Replaces the current "OR of received data" LED indication with a real link-integrity check.

---
 rtl/gbt_check_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/gbt_rx_pattern_checker.sv | 145 ++++++++++++++
 tb/tb_gbt_rx_pattern_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbt_check_pkg.sv
// Shared types and default thresholds for the GBT RX pattern checker.
// Pure declarations: no latency, no flow control.
package gbt_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } t_chk_state;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LOCK_THR   = 16;
    localparam int DEF_UNLOCK_THR = 4;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter; clear wins over increment but keeps a same-cycle hit as 1.
// One-cycle update latency; no backpressure, counts every qualified inc_i.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_ik,
    input  logic         rstn_ir,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/gbt_rx_pattern_checker.sv
// Checks the far end sends an incrementing counter: lock/unlock FSM with flywheel expected value.
// Status and counters are registered one cycle after the frame strobe; no backpressure.
module gbt_rx_pattern_checker
    import gbt_check_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOCK_THR   = DEF_LOCK_THR,
    parameter int UNLOCK_THR = DEF_UNLOCK_THR,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk_ik,
    input  logic              rstn_ir,
    input  logic              los_i,
    input  logic              rx_ready_i,
    input  logic              data_valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic [1:0]        state_o,
    output logic              locked_o,
    output logic              err_strobe_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [CNT_W-1:0]  lol_cnt_o
);

    localparam int GOOD_W = $clog2(LOCK_THR + 1);
    localparam int BAD_W  = $clog2(UNLOCK_THR + 1);
    localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_THR - 1);
    localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_THR - 1);

    t_chk_state        state_q, state_nxt;
    logic [DATA_W-1:0] exp_q, exp_nxt;
    logic [GOOD_W-1:0] good_q, good_nxt;
    logic [BAD_W-1:0]  bad_q, bad_nxt;
    logic              match;
    logic              link_down;
    logic              err_inc, frm_inc, lol_inc;
    logic              locked_q, strobe_q;

    assign match     = (data_i == exp_q);
    assign link_down = los_i || !rx_ready_i;

    always_ff @(posedge clk_ik or negedge rstn_ir) begin
        if (!rstn_ir) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            exp_q    <= exp_nxt;
            good_q   <= good_nxt;
            bad_q    <= bad_nxt;
            locked_q <= (state_nxt == LOCKED);
            strobe_q <= err_inc;
        end
    end

    always_comb begin
        state_nxt = state_q;
        exp_nxt   = exp_q;
        good_nxt  = good_q;
        bad_nxt   = bad_q;
        err_inc   = 1'b0;
        frm_inc   = 1'b0;
        lol_inc   = 1'b0;
        // Link loss overrides everything, including a frame arriving this cycle.
        if (link_down) begin
            state_nxt = IDLE;
            good_nxt  = '0;
            bad_nxt   = '0;
            lol_inc   = (state_q == LOCKED);
        end else begin
            case (state_q)
                SEARCH: begin
                    if (data_valid_i) begin
                        exp_nxt = data_i + DATA_W'(1);
                        if (!match) begin
                            good_nxt = '0;
                        end else if (good_q == LOCK_LAST) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                        end else begin
                            good_nxt = good_q + GOOD_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (data_valid_i) begin
                        frm_inc = 1'b1;
                        exp_nxt = exp_q + DATA_W'(1);
                        if (match) begin
                            bad_nxt = '0;
                        end else begin
                            err_inc = 1'b1;
                            if (bad_q == UNLOCK_LAST) begin
                                state_nxt = SEARCH;
                                lol_inc   = 1'b1;
                                good_nxt  = '0;
                            end else begin
                                bad_nxt = bad_q + BAD_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    // IDLE and the unused encoding both wait here for the link.
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_ik (clk_ik),
        .rstn_ir(rstn_ir),
        .clr_i  (clear_i),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk_ik (clk_ik),
        .rstn_ir(rstn_ir),
        .clr_i  (clear_i),
        .inc_i  (frm_inc),
        .cnt_o  (frame_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_lol_cnt (
        .clk_ik (clk_ik),
        .rstn_ir(rstn_ir),
        .clr_i  (clear_i),
        .inc_i  (lol_inc),
        .cnt_o  (lol_cnt_o)
    );

    assign state_o      = state_q;
    assign locked_o     = locked_q;
    assign err_strobe_o = strobe_q;

endmodule

// File: tb/tb_gbt_rx_pattern_checker.sv
// Bench for gbt_rx_pattern_checker: directed stream phases, per-cycle scoreboard plus milestone checks.
module tb_gbt_rx_pattern_checker;
    import gbt_check_pkg::*;

    localparam int DW = 32;
    localparam int LT = 16;
    localparam int UT = 4;
    localparam int CW = 8;

    logic          clk_ik = 1'b0;
    logic          rstn_ir = 1'b0;
    logic          los_i = 1'b1;
    logic          rx_ready_i = 1'b0;
    logic          data_valid_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          clear_i = 1'b0;
    logic [1:0]    state_o;
    logic          locked_o;
    logic          err_strobe_o;
    logic [CW-1:0] err_cnt_o;
    logic [CW-1:0] frame_cnt_o;
    logic [CW-1:0] lol_cnt_o;

    gbt_rx_pattern_checker #(
        .DATA_W(DW), .LOCK_THR(LT), .UNLOCK_THR(UT), .CNT_W(CW)
    ) dut (
        .clk_ik(clk_ik), .rstn_ir(rstn_ir), .los_i(los_i), .rx_ready_i(rx_ready_i),
        .data_valid_i(data_valid_i), .data_i(data_i), .clear_i(clear_i),
        .state_o(state_o), .locked_o(locked_o), .err_strobe_o(err_strobe_o),
        .err_cnt_o(err_cnt_o), .frame_cnt_o(frame_cnt_o), .lol_cnt_o(lol_cnt_o)
    );

    always #5 clk_ik = ~clk_ik;

    typedef struct packed {
        logic [1:0]    st;
        logic          lk;
        logic          stb;
        logic [CW-1:0] err;
        logic [CW-1:0] frm;
        logic [CW-1:0] lol;
    } obs_t;

    obs_t          sb_q[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] word;

    // Reference model state
    t_chk_state    m_st = IDLE;
    int            m_good = 0;
    int            m_bad = 0;
    logic [DW-1:0] m_exp = '0;
    logic [CW-1:0] m_err = '0, m_frm = '0, m_lol = '0;

    function automatic logic [CW-1:0] upd(input logic [CW-1:0] c, input logic inc, input logic clr);
        if (clr) return inc ? CW'(1) : CW'(0);
        if (inc && c != {CW{1'b1}}) return c + CW'(1);
        return c;
    endfunction

    task automatic step(input logic los, input logic rdy, input logic vld,
                        input logic [DW-1:0] dat, input logic clr);
        logic ei, fi, li;
        t_chk_state nx;
        @(negedge clk_ik);
        los_i = los; rx_ready_i = rdy; data_valid_i = vld; data_i = dat; clear_i = clr;
        ei = 1'b0; fi = 1'b0; li = 1'b0; nx = m_st;
        if (los || !rdy) begin
            li = (m_st == LOCKED);
            nx = IDLE;
            m_good = 0;
        end else if (m_st == IDLE) begin
            nx = SEARCH;
            m_good = 0;
        end else if (vld && m_st == SEARCH) begin
            if (dat == m_exp) begin
                m_good++;
                if (m_good == LT) begin nx = LOCKED; m_bad = 0; end
            end else begin
                m_good = 0;
            end
            m_exp = dat + 1;
        end else if (vld) begin
            fi = 1'b1;
            if (dat != m_exp) begin
                ei = 1'b1;
                m_bad++;
                if (m_bad == UT) begin nx = SEARCH; li = 1'b1; m_good = 0; end
            end else begin
                m_bad = 0;
            end
            m_exp = m_exp + 1;
        end
        m_st  = nx;
        m_err = upd(m_err, ei, clr);
        m_frm = upd(m_frm, fi, clr);
        m_lol = upd(m_lol, li, clr);
        sb_q.push_back('{st: m_st, lk: (m_st == LOCKED), stb: ei, err: m_err, frm: m_frm, lol: m_lol});
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 1'b1, word, 1'b0);
            word = word + 1;
        end
    endtask

    task automatic settle();
        @(posedge clk_ik);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per driven cycle, compared just after the edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk_ik);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = '{st: state_o, lk: locked_o, stb: err_strobe_o,
                      err: err_cnt_o, frm: frame_cnt_o, lol: lol_cnt_o};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL sb_cycle @%0t: got %h want %h", $time, a, e);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk_ik);
        settle();
        chk("reset", {state_o, locked_o, err_strobe_o, err_cnt_o, frame_cnt_o, lol_cnt_o}, 32'h0);
        @(negedge clk_ik);
        rstn_ir = 1'b1;
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        settle();
        chk("idle_to_search", state_o, 32'd1);

        // 1: one resync frame plus sixteen good frames to lock
        word = 32'h10;
        feed(16);
        settle();
        chk("p1_not_locked", locked_o, 32'd0);
        feed(1);
        settle();
        chk("p1_locked", locked_o, 32'd1);
        chk("p1_state", state_o, 32'd2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, word, 1'b0);
            word = word + 1;
            step(1'b0, 1'b1, 1'b0, 32'h5555, 1'b0);
        end
        settle();
        chk("p1_frames", frame_cnt_o, 32'd10);
        chk("p1_errs", err_cnt_o, 32'd0);

        // 2: single corrupted word costs one error, flywheel keeps 101 good
        while (word != 32'd100) feed(1);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b0);
        word = word + 1;
        settle();
        chk("p2_strobe", err_strobe_o, 32'd1);
        feed(1);
        settle();
        chk("p2_strobe_off", err_strobe_o, 32'd0);
        chk("p2_errs", err_cnt_o, 32'd1);
        chk("p2_locked", locked_o, 32'd1);
        chk("p2_frames", frame_cnt_o, 32'd69);

        // 3: four consecutive bad words unlock, then relock after 16 good
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, word ^ 32'hFFFF_0000, 1'b0);
            word = word + 1;
        end
        settle();
        chk("p3_state", state_o, 32'd1);
        chk("p3_lol", lol_cnt_o, 32'd1);
        chk("p3_errs", err_cnt_o, 32'd5);
        feed(15);
        settle();
        chk("p3_not_relocked", locked_o, 32'd0);
        feed(1);
        settle();
        chk("p3_relocked", locked_o, 32'd1);

        // 4: receiver drop, then lock near the top and wrap while locked
        step(1'b0, 1'b0, 1'b1, word, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        word = 32'hFFFF_FFE0;
        feed(17);
        feed(19);
        settle();
        chk("p4_locked", locked_o, 32'd1);
        chk("p4_errs", err_cnt_o, 32'd5);
        chk("p4_frames", frame_cnt_o, 32'd92);
        chk("p4_lol", lol_cnt_o, 32'd2);

        // 5: LOS alongside a valid frame while locked
        step(1'b1, 1'b1, 1'b1, word, 1'b0);
        settle();
        chk("p5_state", state_o, 32'd0);
        chk("p5_unlocked", locked_o, 32'd0);
        chk("p5_lol", lol_cnt_o, 32'd3);
        chk("p5_frames", frame_cnt_o, 32'd92);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, word + 7, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        settle();
        chk("p5_search", state_o, 32'd1);
        feed(16);
        settle();
        chk("p5_relocked", locked_o, 32'd1);

        // 6: clear precedence and saturation
        step(1'b0, 1'b1, 1'b1, word ^ 32'h1, 1'b1);
        word = word + 1;
        settle();
        chk("p6_clr_err", err_cnt_o, 32'd1);
        chk("p6_clr_frm", frame_cnt_o, 32'd1);
        chk("p6_clr_lol", lol_cnt_o, 32'd0);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        settle();
        chk("p6_clear_all", {err_cnt_o, frame_cnt_o, lol_cnt_o}, 32'd0);
        chk("p6_clear_locked", locked_o, 32'd1);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 1'b1, ~word, 1'b0);
            word = word + 1;
            feed(1);
        end
        settle();
        chk("p6_err_sat", err_cnt_o, 32'd255);
        chk("p6_frm_sat", frame_cnt_o, 32'd255);
        step(1'b0, 1'b1, 1'b1, ~word, 1'b0);
        word = word + 1;
        settle();
        chk("p6_err_stays", err_cnt_o, 32'd255);
        chk("p6_still_locked", locked_o, 32'd1);

        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk_ik);
        #3;
        if (sb_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
